// File: rtl/wx_loader_pkg.sv
// Shared definitions for the wx operand loader and the adder tree it feeds.
// Holds the loader FSM encoding, the per-slot weight width and the wx bus
// width helper used by both the loader and the tree instantiation.
package wx_loader_pkg;

  // Loader FSM: LOAD accepts weight beats, COMMIT copies shadow -> active.
  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_COMMIT = 1'b1
  } wx_state_e;

  // Bits per signed synaptic weight slot (two's complement, -2..1).
  localparam int WBITS = 2;

  // Width of the packed weighted-input bus for a tree of depth n.
  function automatic int WX_W(input int n);
    return 2 ** (n + 1);
  endfunction

endpackage

// File: rtl/wx_loader_if.sv
// Handshake and data bundle between a weight/spike producer and wx_loader.
// Ports: w_valid/w_ready/w_data/w_clear (weight stream), x_valid/x_in
// (spike capture), w_loaded (commit pulse), wx (gated weight bus).
interface wx_loader_if
  import wx_loader_pkg::*;
#(
  parameter int N_STAGE = 5
);
  localparam int NSYN = 2 ** N_STAGE;

  logic                      w_valid;
  logic                      w_ready;
  logic [WBITS-1:0]          w_data;
  logic                      w_clear;
  logic                      x_valid;
  logic [NSYN-1:0]           x_in;
  logic                      w_loaded;
  logic [WX_W(N_STAGE)-1:0]  wx;

  // Producer side.
  modport master (
    output w_valid, w_data, w_clear, x_valid, x_in,
    input  w_ready, w_loaded, wx
  );

  // Loader side.
  modport slave (
    input  w_valid, w_data, w_clear, x_valid, x_in,
    output w_ready, w_loaded, wx
  );

endinterface

// File: rtl/wx_loader_slot_gate.sv
// One wx slot: passes the active weight when the synapse spiked, else zero.
// Ports: x_i (spike bit), w_i (active weight), wx_o (gated weight).
// Purely combinational; no state.
module wx_slot_gate
  import wx_loader_pkg::*;
(
  input  logic             x_i,
  input  logic [WBITS-1:0] w_i,
  output logic [WBITS-1:0] wx_o
);

  assign wx_o = w_i & {WBITS{x_i}};

endmodule

// File: rtl/wx_loader.sv
// Operand front end for the synapse adder tree: streams 2-bit weights into a
// shadow bank, commits it atomically to the active bank, gates by spikes.
// Ports: clk, reset (sync, active-high), bus (wx_loader_if.slave).
module wx_loader
  import wx_loader_pkg::*;
#(
  parameter int N_STAGE = 5
) (
  input  logic        clk,
  input  logic        reset,
  wx_loader_if.slave  bus
);

  localparam int NSYN = 2 ** N_STAGE;
  localparam int BW   = WBITS * NSYN;
  localparam logic [N_STAGE-1:0] IDX_LAST = N_STAGE'(NSYN - 1);

  wx_state_e          state_q;
  logic [N_STAGE-1:0] idx_q;
  logic [BW-1:0]      shadow_q, shadow_d;
  logic [BW-1:0]      active_q;
  logic [NSYN-1:0]    x_q, x_d;
  logic               w_loaded_q;
  logic               accept;
  logic [BW-1:0]      wx_gated;

  // Clear blocks the handshake in the same cycle so the beat it rides with
  // is visibly refused rather than silently dropped.
  assign bus.w_ready = (state_q == ST_LOAD) && !bus.w_clear;
  assign accept      = bus.w_valid && bus.w_ready;

  // Shadow bank write: only the addressed slot changes.
  always_comb begin
    shadow_d = shadow_q;
    if (accept) begin
      shadow_d[WBITS*int'(idx_q) +: WBITS] = bus.w_data;
    end
  end

  assign x_d = bus.x_valid ? bus.x_in : x_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      x_q      <= '0;
    end else begin
      shadow_q <= shadow_d;
      x_q      <= x_d;
    end
  end

  // Load/commit FSM. The active bank is written only in COMMIT, so the tree
  // never sees a partially loaded bank. w_loaded is registered so it lines
  // up with the first cycle the new bank is visible on wx.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      active_q   <= '0;
      w_loaded_q <= 1'b0;
    end else begin
      w_loaded_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (bus.w_clear) begin
            idx_q <= '0;
          end else if (accept) begin
            // idx wraps naturally to 0 after the last slot.
            idx_q <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          // w_clear is deliberately ignored here; the commit always completes.
          active_q   <= shadow_q;
          w_loaded_q <= 1'b1;
          state_q    <= ST_LOAD;
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.w_loaded = w_loaded_q;

  for (genvar k = 0; k < NSYN; k++) begin : g_slot
    wx_slot_gate u_gate (
      .x_i  (x_q[k]),
      .w_i  (active_q[WBITS*k +: WBITS]),
      .wx_o (wx_gated[WBITS*k +: WBITS])
    );
  end

  assign bus.wx = wx_gated;

endmodule
